// File: rtl/y86_seq_param.sv
// y86_seq_param: multi-cycle y86 subset core with a ready-handshake bus.
// Option: define Y86_SEQ_ILLEGAL_TRAP_EN to trap undefined opcodes into HALT.
module y86_seq_param #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int BASE_REG = 6,
  parameter logic [ADDR_W-1:0] RESET_IP = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] bus_A,
  input  logic [DATA_W-1:0] bus_in,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_RE,
  output logic              bus_WE,
  input  logic              bus_ready,
  output logic [7:0]        current_opcode,
  output logic              retired,
  output logic              halted
`ifdef Y86_SEQ_ILLEGAL_TRAP_EN
  ,
  output logic              illegal_op
`endif
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [2:0] BASE_IDX = 3'(BASE_REG);

  state_t r_state;
  state_t w_next;

  logic [ADDR_W-1:0] r_ip;
  logic [ADDR_W-1:0] r_mar;
  logic [31:0]       r_ir;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_c;
  logic [DATA_W-1:0] r_mdrw;
  logic [DATA_W-1:0] r_mdrr;
  logic              r_zf;
  logic [DATA_W-1:0] r_regs [8];
`ifdef Y86_SEQ_ILLEGAL_TRAP_EN
  logic              r_ill;
`endif

  logic [7:0] w_op;
  logic [1:0] w_mod;
  logic [2:0] w_rd;
  logic [2:0] w_rs;
  logic [7:0] w_d8;
  logic [7:0] w_disp;

  logic w_load;
  logic w_store;
  logic w_move;
  logic w_add;
  logic w_sub;
  logic w_jnz;
  logic w_hlt;
  logic w_mem;
  logic w_trap;
  logic w_stop;

  logic [1:0]        w_len;
  logic [ADDR_W-1:0] w_br;
  logic [ADDR_W-1:0] w_ip_nxt;
  logic [DATA_W-1:0] w_op2;
  logic [DATA_W-1:0] w_sum;
  logic              w_unused_ok;

  assign w_op   = r_ir[7:0];
  assign w_mod  = r_ir[15:14];
  assign w_rd   = r_ir[10:8];
  assign w_rs   = r_ir[13:11];
  assign w_d8   = r_ir[15:8];
  assign w_disp = r_ir[23:16];

  assign w_load  = (w_op == 8'h8B) && (w_mod == 2'b01);
  assign w_store = (w_op == 8'h89) && (w_mod == 2'b01);
  assign w_move  = (w_op == 8'h89) && (w_mod == 2'b11);
  assign w_add   = (w_op == 8'h01);
  assign w_sub   = (w_op == 8'h29);
  assign w_jnz   = (w_op == 8'h75);
  assign w_hlt   = (w_op == 8'hF4);
  assign w_mem   = w_load | w_store;

`ifdef Y86_SEQ_ILLEGAL_TRAP_EN
  assign w_trap = ~(w_mem | w_move | w_add | w_sub | w_jnz | w_hlt);
  assign illegal_op = r_ill;
`else
  assign w_trap = 1'b0;
`endif

  assign w_stop = w_hlt | w_trap;

  // instruction length from the decoded class
  always_comb begin
    w_len = 2'd1;
    unique case (1'b1)
      w_mem:                   w_len = 2'd3;
      w_move, w_add,
      w_sub, w_jnz:            w_len = 2'd2;
      default:                 w_len = 2'd1;
    endcase
  end

  assign w_br = (w_jnz && !r_zf)
    ? {{(ADDR_W-8){w_d8[7]}}, w_d8}
    : '0;
  assign w_ip_nxt = r_ip + ADDR_W'(w_len) + w_br;

  assign w_op2 = w_mem ? {{(DATA_W-8){w_disp[7]}}, w_disp}
               : w_sub ? (~r_b + 1'b1)
               : r_b;
  assign w_sum = r_a + w_op2;

  assign w_unused_ok = &{1'b0, r_ir[31:24], bus_in};

  assign current_opcode = w_op;
  assign bus_out = r_mdrw;

  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  // next state and bus/status outputs
  always_comb begin
    w_next  = r_state;
    bus_A   = '0;
    bus_RE  = 1'b0;
    bus_WE  = 1'b0;
    retired = 1'b0;
    halted  = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        bus_A  = r_ip;
        bus_RE = 1'b1;
        if (bus_ready) w_next = S_DECODE;
      end
      S_DECODE: w_next = w_stop ? S_HALT : S_EXEC;
      S_EXEC:   w_next = w_mem ? S_MEM : S_WB;
      S_MEM: begin
        bus_A  = r_mar;
        bus_RE = w_load;
        bus_WE = w_store;
        if (bus_ready) w_next = S_WB;
      end
      S_WB: begin
        retired = 1'b1;
        w_next  = S_FETCH;
      end
      S_HALT:   halted = 1'b1;
      default:  w_next = S_FETCH;
    endcase
  end

  // datapath registers, register file and flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ip   <= RESET_IP;
      r_ir   <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_c    <= '0;
      r_mar  <= '0;
      r_mdrw <= '0;
      r_mdrr <= '0;
      r_zf   <= 1'b0;
      for (int i = 0; i < 8; i++) r_regs[i] <= '0;
`ifdef Y86_SEQ_ILLEGAL_TRAP_EN
      r_ill  <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        S_FETCH: begin
          if (bus_ready) r_ir <= bus_in[31:0];
        end
        S_DECODE: begin
          r_a <= w_mem ? r_regs[BASE_IDX] : r_regs[w_rd];
          r_b <= r_regs[w_rs];
          if (!w_stop) r_ip <= w_ip_nxt;
`ifdef Y86_SEQ_ILLEGAL_TRAP_EN
          if (w_trap) r_ill <= 1'b1;
`endif
        end
        S_EXEC: begin
          r_mar  <= ADDR_W'(w_sum);
          r_c    <= w_move ? r_b : w_sum;
          r_mdrw <= r_b;
          if (w_add || w_sub) r_zf <= (w_sum == '0);
        end
        S_MEM: begin
          if (bus_ready && w_load) r_mdrr <= bus_in;
        end
        S_WB: begin
          if (w_load) r_regs[w_rs] <= r_mdrr;
          else if (w_add || w_sub || w_move) r_regs[w_rd] <= r_c;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_y86_seq_param.sv
// tb_y86_seq_param: vector table plus store scoreboard
// and hand sequences for wait states, reset, branches and halt.
module tb_y86_seq_param;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] bus_A;
  logic [31:0] bus_in;
  logic [31:0] bus_out;
  logic        bus_RE;
  logic        bus_WE;
  logic        bus_ready = 1'b1;
  logic [7:0]  current_opcode;
  logic        retired;
  logic        halted;
`ifdef Y86_SEQ_ILLEGAL_TRAP_EN
  logic        illegal_op;
`endif

  y86_seq_param dut (
    .clk(clk),
    .rst(rst),
    .bus_A(bus_A),
    .bus_in(bus_in),
    .bus_out(bus_out),
    .bus_RE(bus_RE),
    .bus_WE(bus_WE),
    .bus_ready(bus_ready),
    .current_opcode(current_opcode),
    .retired(retired),
`ifdef Y86_SEQ_ILLEGAL_TRAP_EN
    .illegal_op(illegal_op),
`endif
    .halted(halted)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [4096];
  assign bus_in = {mem[bus_A[11:0] + 12'd3], mem[bus_A[11:0] + 12'd2],
                   mem[bus_A[11:0] + 12'd1], mem[bus_A[11:0]]};

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } st_t;
  st_t sb[$];
  st_t e;

  int n_vec = 0;
  int n_fail = 0;
  int cyc, ret_cnt, we_cyc, halt_at, first_ret;
  logic [31:0] last_rd;
  int mode = 0;
  int wcnt = 0;

  // ready driver: 0 always ready, 1 random, 2 stall writes 3 cycles
  always @(posedge clk) begin
    #1;
    case (mode)
      0: bus_ready = 1'b1;
      1: bus_ready = ($urandom_range(0, 2) != 0);
      default: begin
        if (bus_WE && wcnt < 3) begin
          bus_ready = 1'b0;
          wcnt++;
        end else begin
          bus_ready = 1'b1;
          if (!bus_WE) wcnt = 0;
        end
      end
    endcase
  end

  // monitor: cycle count, retire/halt tracking, store scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      cyc++;
      if (retired) begin
        ret_cnt++;
        if (first_ret == 0) first_ret = cyc;
      end
      if (bus_WE) we_cyc++;
      if (bus_RE && bus_ready) last_rd = bus_A;
      if (halted && halt_at == 0) halt_at = cyc;
      if (bus_WE && bus_ready) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL store_unexpected: addr %h data %h", bus_A, bus_out);
        end else begin
          e = sb.pop_front();
          if (bus_A !== e.addr || bus_out !== e.data) begin
            n_fail++;
            $display("FAIL store: got addr %h data %h, expected addr %h data %h",
                     bus_A, bus_out, e.addr, e.data);
          end
        end
        mem[bus_A[11:0]]         = bus_out[7:0];
        mem[bus_A[11:0] + 12'd1] = bus_out[15:8];
        mem[bus_A[11:0] + 12'd2] = bus_out[23:16];
        mem[bus_A[11:0] + 12'd3] = bus_out[31:24];
      end
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clear_mem();
    foreach (mem[i]) mem[i] = 8'h00;
    sb.delete();
  endtask

  task automatic put32(int a, logic [31:0] d);
    mem[a]     = d[7:0];
    mem[a + 1] = d[15:8];
    mem[a + 2] = d[23:16];
    mem[a + 3] = d[31:24];
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    cyc = 0;
    ret_cnt = 0;
    we_cyc = 0;
    halt_at = 0;
    first_ret = 0;
    last_rd = '0;
    rst = 1'b0;
  endtask

  task automatic cycles(int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic run_halt(int maxc);
    while (halt_at == 0 && cyc < maxc) begin
      @(negedge clk);
      #1;
    end
    n_vec++;
    if (halt_at == 0) begin
      n_fail++;
      $display("FAIL halt_timeout: no halt after %0d cycles", cyc);
    end
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        zf;
    int          md;
  } vec_t;

  vec_t v[7];

  initial begin
    v[0] = '{8'h01, 32'd3,        32'd4,        32'd7,        1'b0, 0};
    v[1] = '{8'h01, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1};
    v[2] = '{8'h29, 32'd5,        32'd5,        32'd0,        1'b1, 0};
    v[3] = '{8'h29, 32'd3,        32'd5,        32'hFFFFFFFE, 1'b0, 1};
    v[4] = '{8'h89, 32'h1111,     32'h1234,     32'h1234,     1'b0, 0};
    v[5] = '{8'h01, 32'h80000000, 32'h80000000, 32'd0,        1'b1, 1};
    v[6] = '{8'h29, 32'd0,        32'd1,        32'hFFFFFFFF, 1'b0, 0};

    // ALU/move table: load R1,R2; op R1,R2; store R1; jnez on ZF
    for (int i = 0; i < 7; i++) begin
      clear_mem();
      mem[0] = 8'h8B; mem[1] = 8'h4E; mem[2] = 8'h40;
      mem[3] = 8'h8B; mem[4] = 8'h56; mem[5] = 8'h44;
      mem[6] = v[i].op; mem[7] = 8'hD1;
      mem[8] = 8'h89; mem[9] = 8'h4E; mem[10] = 8'h48;
      mem[11] = 8'h75; mem[12] = 8'h01;
      mem[13] = 8'hF4; mem[14] = 8'hF4;
      put32(32'h40, v[i].a);
      put32(32'h44, v[i].b);
      sb.push_back('{32'h48, v[i].res});
      mode = v[i].md;
      do_reset();
      run_halt(400);
      chk($sformatf("vec%0d_halt_ip", i), last_rd, v[i].zf ? 32'd13 : 32'd14);
      chk($sformatf("vec%0d_retired", i), ret_cnt, 32'd5);
      chk($sformatf("vec%0d_sb_empty", i), sb.size(), 32'd0);
    end

    // reset state and add R0,R3 timing
    clear_mem();
    mem[0] = 8'h01; mem[1] = 8'hD8;
    mem[2] = 8'h75; mem[3] = 8'h01;
    mem[4] = 8'hF4; mem[5] = 8'hF4;
    mode = 0;
    do_reset();
    cycles(1);
    chk("rst_bus_RE", bus_RE, 1);
    chk("rst_bus_A", bus_A, 0);
    chk("rst_bus_WE", bus_WE, 0);
    chk("rst_halted", halted, 0);
    chk("rst_retired", retired, 0);
    cycles(3);
    chk("add_retired_c4", retired, 1);
    cycles(1);
    chk("add_next_ip", bus_A, 2);
    run_halt(100);
    chk("add_zf_halt_ip", last_rd, 4);

    // load with base register
    clear_mem();
    mem[0] = 8'h8B; mem[1] = 8'h76; mem[2] = 8'h60;
    mem[3] = 8'h8B; mem[4] = 8'h46; mem[5] = 8'h04;
    mem[6] = 8'h89; mem[7] = 8'h46; mem[8] = 8'h48;
    mem[9] = 8'hF4;
    put32(32'h60, 32'h100);
    put32(32'h104, 32'hDEADBEEF);
    sb.push_back('{32'h148, 32'hDEADBEEF});
    do_reset();
    cycles(9);
    chk("load_bus_A", bus_A, 32'h104);
    chk("load_bus_RE", bus_RE, 1);
    chk("load_opcode", current_opcode, 8'h8B);
    cycles(1);
    chk("load_retired_c10", retired, 1);
    run_halt(100);
    chk("load_sb_empty", sb.size(), 0);

    // store with three wait states
    clear_mem();
    mem[0] = 8'h89; mem[1] = 8'h46; mem[2] = 8'h48;
    mem[3] = 8'hF4;
    put32(32'h48, 32'hFFFFFFFF);
    sb.push_back('{32'h48, 32'h0});
    mode = 2;
    do_reset();
    cycles(4);
    chk("st_we_c4", bus_WE, 1);
    chk("st_mar_c4", bus_A, 32'h48);
    cycles(3);
    chk("st_we_c7", bus_WE, 1);
    chk("st_mar_c7", bus_A, 32'h48);
    run_halt(100);
    chk("st_we_cycles", we_cyc, 4);
    chk("st_retire_cycle", first_ret, 8);
    chk("st_sb_empty", sb.size(), 0);

    // reset during a stalled write abandons it
    sb.push_back('{32'h48, 32'h0});
    do_reset();
    cycles(5);
    chk("midwait_we", bus_WE, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midwait_rst_RE", bus_RE, 1);
    chk("midwait_rst_A", bus_A, 0);
    chk("midwait_rst_WE", bus_WE, 0);
    do_reset();
    run_halt(100);
    chk("midwait_sb_empty", sb.size(), 0);
    chk("midwait_retired", ret_cnt, 1);
    mode = 0;

    // jnez backward, ZF=0
    clear_mem();
    mem[0] = 8'h75; mem[1] = 8'h0E;
    mem[16] = 8'h75; mem[17] = 8'hFC;
    mem[14] = 8'hF4;
    do_reset();
    run_halt(100);
    chk("jnez_taken", last_rd, 32'h0E);

    // jnez with ZF=1 falls through
    clear_mem();
    mem[0] = 8'h75; mem[1] = 8'h0C;
    mem[14] = 8'h01; mem[15] = 8'hC0;
    mem[16] = 8'h75; mem[17] = 8'hFC;
    mem[18] = 8'hF4;
    do_reset();
    run_halt(100);
    chk("jnez_not_taken", last_rd, 32'h12);

    // halt at 0x20 is absorbing until reset
    clear_mem();
    mem[0] = 8'h75; mem[1] = 8'h1E;
    mem[32] = 8'hF4;
    do_reset();
    run_halt(100);
    chk("halt_ip", last_rd, 32'h20);
    chk("halt_cycle", halt_at, 7);
    cycles(3);
    chk("halt_no_RE", bus_RE, 0);
    chk("halt_no_WE", bus_WE, 0);
    chk("halt_held", halted, 1);
    chk("halt_retired", ret_cnt, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("halt_rst_RE", bus_RE, 1);
    chk("halt_rst_A", bus_A, 0);
    chk("halt_rst_halted", halted, 0);

    // backward branch below zero wraps
    clear_mem();
    mem[0] = 8'h75; mem[1] = 8'hF0;
    mem[12'hFF2] = 8'hF4;
    do_reset();
    run_halt(100);
    chk("wrap_ip", last_rd, 32'hFFFFFFF2);

    // undefined opcode 0x90
    clear_mem();
    mem[0] = 8'h90;
    mem[1] = 8'hF4;
    do_reset();
    run_halt(100);
`ifdef Y86_SEQ_ILLEGAL_TRAP_EN
    chk("ill_halt_ip", last_rd, 0);
    chk("ill_retired", ret_cnt, 0);
    chk("ill_flag", illegal_op, 1);
`else
    chk("nop_halt_ip", last_rd, 1);
    chk("nop_retired", ret_cnt, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
